intra4_dc_sched: RTL
====================

// Module: intra4_dc_sched
// PURPOSE
//  Sequences 4x4 DC intra prediction across one 16x16 luma macroblock.
//  - Walks the 16 sub-blocks in raster order and selects top/left neighbours for each.
//  - Neighbours come from the MB border, or from reconstructed pixels of earlier sub-blocks.
//  - Computes the DC value and emits the 16-pixel predicted block over a valid/ready handshake.
//  - Waits for the reconstructed block before advancing; sits between MB border buffers and residual/recon path.
// PARAMETERS
//  BIT_WIDTH   8    pixel width in bits
//  BLOCK_SIZE  4    sub-block edge in pixels
//  MB_SIZE     16   macroblock edge in pixels
// PORTS
//  clk          in   1                        clock, rising edge
//  rst          in   1                        asynchronous, active-high reset
//  start        in   1                        pulse: begin a new macroblock (ignored unless IDLE)
//  top_avail    in   1                        MB row above exists (sampled on accepted start)
//  left_avail   in   1                        MB column to the left exists (sampled on accepted start)
//  mb_top       in   BIT_WIDTH*MB_SIZE        16 pixels above MB, px0 in LSBs (sampled on start)
//  mb_left      in   BIT_WIDTH*MB_SIZE        16 pixels left of MB, row0 in LSBs (sampled on start)
//  pred_valid   out  1                        pred_dst/pred_idx valid
//  pred_ready   in   1                        consumer accepts prediction
//  pred_idx     out  4                        sub-block index 0..15 (row*4+col)
//  pred_dc      out  BIT_WIDTH                DC value of current sub-block
//  pred_dst     out  BIT_WIDTH*16             DC replicated to 16 pixels, raster, px0 in LSBs
//  recon_valid  in   1                        reconstructed block for pred_idx present
//  recon_blk    in   BIT_WIDTH*16             reconstructed 4x4, raster, px0 in LSBs
//  busy         out  1                        high from accepted start until done
//  done         out  1                        one-cycle pulse after block 15 recon accepted
// BEHAVIOUR
//  Reset: state=IDLE; pred_valid=0, pred_idx=0, pred_dc=0, pred_dst=0, busy=0, done=0; neighbour regs cleared.
//  States and transitions:
//   IDLE  -> LOAD on start; latch mb_top/mb_left/avail flags; idx=0.
//   LOAD  -> CALC; select the 4 top and 4 left neighbours of idx into registers.
//   CALC  -> OUT; register the DC result.
//   OUT   holds pred_valid=1 with stable outputs until pred_ready -> WAIT.
//   WAIT  on recon_valid: store bottom row into top_line[col]; store right column into left_col.
//         idx==15 -> DONE; else idx+1 -> LOAD.
//   DONE  -> IDLE; done=1 for exactly this cycle.
//  Latency: start -> first pred_valid = 3 cycles; recon_valid -> next pred_valid = 3 cycles.
//  Neighbour availability for sub-block (r,c):
//   top exists  = (r>0) | top_avail_l;   source = row r-1 ? top_line[c] : mb_top[c].
//   left exists = (c>0) | left_avail_l;  source = col c-1 ? left_col : mb_left rows 4r..4r+3.
//  DC arithmetic:
//   Sums use 11-bit adders (4 or 8 terms of 8 bits); no overflow possible.
//   both exist: (sum8 + 4) >> 3;  top only: (sumT + 2) >> 2;  left only: (sumL + 2) >> 2.
//   neither: 1 << (BIT_WIDTH-1) = 128.
//  Handshake:
//   pred_* must not change while pred_valid && !pred_ready.
//   recon_valid is ignored outside WAIT; one recon is consumed per block.
//   recon_valid in the same cycle as the pred handshake is ignored (earliest accept = next cycle).
//  Boundaries:
//   start while busy is ignored; start coincident with done is ignored.
//   rst mid-MB aborts to IDLE with all outputs at reset values and no done pulse.
//   left_col is reloaded from mb_left at c==0 of every block row.
//   top_line persists across rows within the MB; it is cleared on start.
// STRUCTURE
//  Shared package: state enum (IDLE, LOAD, CALC, OUT, WAIT, DONE); DC_MID = 128; sub-block index width 4.
//  One sub-module: dc4_avg.
//   Combinational; inputs 4 top + 4 left pixels plus use_top/use_left; output the rounded DC per the rules above.
//   Instantiated once; the controller owns all state, neighbour storage and handshakes.
// TESTING
//  1. top_avail=left_avail=0, recon all 0x00 -> idx0 dc=128; later blocks use recon zeros (row0 idx1 dc=0).
//  2. Both avail, mb_top all 10, mb_left all 20, recon echoes pred -> idx0 dc=15; 16 preds, then done pulse.
//  3. top_avail=1, left_avail=0, mb_top=1,2,3,4,... -> idx0 dc=(10+2)>>2=3; idx1 uses recon left.
//  4. Hold pred_ready=0 for 5 cycles -> pred_dst/pred_idx stable; pulse recon_valid during OUT -> ignored.
//  5. Assert rst at idx=7 -> all outputs 0 next cycle; new start restarts at idx0 with no done pulse.
//  6. start during busy, and all-0xFF neighbours -> start ignored; dc=255, no overflow.

Source files
------------

// File: rtl/intra4_dc_sched_pkg.sv
// Shared definitions for the 4x4 DC intra prediction sequencer.
package intra4_dc_sched_pkg;

    // Controller states, one per phase of a sub-block.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CALC = 3'd2,
        OUT  = 3'd3,
        WAIT = 3'd4,
        DONE = 3'd5
    } state_t;

    // DC used when neither neighbour exists (mid-grey for 8-bit pixels).
    localparam int DC_MID = 128;

    // Sub-block index width: 16 sub-blocks per macroblock.
    localparam int IDX_W = 4;

endpackage

// File: rtl/intra4_dc_sched_dc4_avg.sv
// Combinational rounded DC average of the top and left neighbours of one
// 4x4 sub-block. Missing neighbours are excluded from the average; with no
// neighbours at all the mid-grey value is produced.
module dc4_avg
    import intra4_dc_sched_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 4
) (
    input  logic [BLOCK_SIZE*BIT_WIDTH-1:0] top,
    input  logic [BLOCK_SIZE*BIT_WIDTH-1:0] left,
    input  logic                            use_top,
    input  logic                            use_left,
    output logic [BIT_WIDTH-1:0]            dc
);

    // Room for 2*BLOCK_SIZE terms plus the rounding offset without overflow.
    localparam int SUM_W  = BIT_WIDTH + $clog2(2 * BLOCK_SIZE);
    localparam int SH_ONE = $clog2(BLOCK_SIZE);
    localparam int SH_TWO = $clog2(2 * BLOCK_SIZE);
    localparam logic [BIT_WIDTH-1:0] MID =
        (BIT_WIDTH == 8) ? BIT_WIDTH'(DC_MID) : (BIT_WIDTH'(1) << (BIT_WIDTH - 1));

    // Round-half-up right shift of an unsigned sum.
    function automatic logic [BIT_WIDTH-1:0] round_shr(input logic [SUM_W-1:0] s,
                                                       input int sh);
        logic [SUM_W-1:0] r;
        r = s + (SUM_W'(1) << (sh - 1));
        return BIT_WIDTH'(r >> sh);
    endfunction

    logic [SUM_W-1:0] sum_t;
    logic [SUM_W-1:0] sum_l;

    // Accumulate each neighbour edge separately.
    always_comb begin
        sum_t = '0;
        sum_l = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            sum_t = sum_t + SUM_W'(top[i*BIT_WIDTH +: BIT_WIDTH]);
            sum_l = sum_l + SUM_W'(left[i*BIT_WIDTH +: BIT_WIDTH]);
        end
    end

    // Pick the average that matches which neighbours exist.
    always_comb begin
        dc = MID;
        if (use_top && use_left) begin
            dc = round_shr(sum_t + sum_l, SH_TWO);
        end else if (use_top) begin
            dc = round_shr(sum_t, SH_ONE);
        end else if (use_left) begin
            dc = round_shr(sum_l, SH_ONE);
        end
    end

endmodule

// File: rtl/intra4_dc_sched.sv
// Sequences 4x4 DC intra prediction over one 16x16 luma macroblock: walks
// sub-blocks in raster order, gathers neighbours from the MB border or from
// previously reconstructed sub-blocks, emits the predicted block over a
// valid/ready handshake, and waits for the reconstruction before advancing.
module intra4_dc_sched
    import intra4_dc_sched_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 4,
    parameter int MB_SIZE    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          top_avail,
    input  logic                          left_avail,
    input  logic [BIT_WIDTH*MB_SIZE-1:0]  mb_top,
    input  logic [BIT_WIDTH*MB_SIZE-1:0]  mb_left,
    output logic                          pred_valid,
    input  logic                          pred_ready,
    output logic [IDX_W-1:0]              pred_idx,
    output logic [BIT_WIDTH-1:0]          pred_dc,
    output logic [BIT_WIDTH*16-1:0]       pred_dst,
    input  logic                          recon_valid,
    input  logic [BIT_WIDTH*16-1:0]       recon_blk,
    output logic                          busy,
    output logic                          done
);

    // One sub-block edge worth of pixels.
    localparam int SEG  = BLOCK_SIZE * BIT_WIDTH;
    localparam int LINE = MB_SIZE * BIT_WIDTH;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [1:0]           row;
    logic [1:0]           col;
    logic                 top_avail_l;
    logic                 left_avail_l;
    logic [LINE-1:0]      mb_top_l;
    logic [LINE-1:0]      mb_left_l;
    logic [LINE-1:0]      top_line;
    logic [SEG-1:0]       left_col;
    logic [SEG-1:0]       nb_top;
    logic [SEG-1:0]       nb_left;
    logic                 use_top;
    logic                 use_left;
    logic [SEG-1:0]       sel_top;
    logic [SEG-1:0]       sel_left;
    logic [SEG-1:0]       recon_bottom;
    logic [SEG-1:0]       recon_right;
    logic [BIT_WIDTH-1:0] dc_val;

    assign row = idx[3:2];
    assign col = idx[1:0];

    // Neighbour source: MB border on the first row/column, reconstruction otherwise.
    always_comb begin
        sel_top  = (row != 2'd0) ? top_line[int'(col)*SEG +: SEG]
                                 : mb_top_l[int'(col)*SEG +: SEG];
        sel_left = (col != 2'd0) ? left_col
                                 : mb_left_l[int'(row)*SEG +: SEG];
    end

    // Bottom row and right column of the reconstructed block feed later neighbours.
    always_comb begin
        recon_bottom = recon_blk[(BLOCK_SIZE-1)*SEG +: SEG];
        recon_right  = '0;
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            recon_right[k*BIT_WIDTH +: BIT_WIDTH] =
                recon_blk[(k*BLOCK_SIZE + BLOCK_SIZE - 1)*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    dc4_avg #(
        .BIT_WIDTH (BIT_WIDTH),
        .BLOCK_SIZE(BLOCK_SIZE)
    ) u_dc4_avg (
        .top     (nb_top),
        .left    (nb_left),
        .use_top (use_top),
        .use_left(use_left),
        .dc      (dc_val)
    );

    // Controller: sequencing, neighbour storage and both handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            top_avail_l  <= 1'b0;
            left_avail_l <= 1'b0;
            mb_top_l     <= '0;
            mb_left_l    <= '0;
            top_line     <= '0;
            left_col     <= '0;
            nb_top       <= '0;
            nb_left      <= '0;
            use_top      <= 1'b0;
            use_left     <= 1'b0;
            pred_valid   <= 1'b0;
            pred_idx     <= '0;
            pred_dc      <= '0;
            pred_dst     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        top_avail_l  <= top_avail;
                        left_avail_l <= left_avail;
                        mb_top_l     <= mb_top;
                        mb_left_l    <= mb_left;
                        top_line     <= '0;
                        left_col     <= '0;
                        idx          <= '0;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    nb_top   <= sel_top;
                    nb_left  <= sel_left;
                    use_top  <= (row != 2'd0) || top_avail_l;
                    use_left <= (col != 2'd0) || left_avail_l;
                    state    <= CALC;
                end
                CALC: begin
                    pred_dc    <= dc_val;
                    pred_dst   <= {16{dc_val}};
                    pred_idx   <= idx;
                    pred_valid <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    // Outputs stay frozen until the consumer takes them.
                    if (pred_ready) begin
                        pred_valid <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (recon_valid) begin
                        top_line[int'(col)*SEG +: SEG] <= recon_bottom;
                        left_col                       <= recon_right;
                        if (idx == 4'd15) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
